// File: rtl/out_mux_arb_pkg.sv
// Shared definitions for the result-return multiplexer: operation-word field
// positions (identical to the input demux packing), FSM states and helpers.
package out_mux_arb_pkg;

    localparam int ADDR_MSB    = 21;
    localparam int ADDR_LSB    = 17;
    localparam int WR_RD_BIT   = 16;
    localparam int DATA_MSB    = 15;
    localparam int DATA_LSB    = 8;
    localparam int OPID_MSB    = 7;
    localparam int OPID_LSB    = 0;
    localparam int SW_ID_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Round-robin successor of an instance index, wrapping at n.
    function automatic logic [SW_ID_WIDTH-1:0] next_ptr(input logic [SW_ID_WIDTH-1:0] cur,
                                                        input int n);
        if (int'(cur) >= n - 1) return '0;
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/out_mux_arb_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or above ptr,
// wrapping to the lowest requesting index below ptr.
module rr_arbiter
    import out_mux_arb_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]             req,
    input  logic [SW_ID_WIDTH-1:0]   ptr,
    output logic [SW_ID_WIDTH-1:0]   gnt_idx,
    output logic                     gnt_vld
);

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_vld && req[i] && (i >= int'(ptr))) begin
                gnt_idx = SW_ID_WIDTH'(i);
                gnt_vld = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_vld && req[i] && (i < int'(ptr))) begin
                gnt_idx = SW_ID_WIDTH'(i);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_mux_arb.sv
// Collects operation words from the per-switch result FIFOs with round-robin
// arbitration and presents them one at a time on the response channel.
module out_mux_arb
    import out_mux_arb_pkg::*;
#(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int OP_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty   [NUM_SW_INST],
    input  logic [OP_WIDTH-1:0]     fifo_rd_data [NUM_SW_INST],
    output logic                    rd_fifo      [NUM_SW_INST],
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [SW_ID_WIDTH-1:0]  out_sw_id,
    output logic [4:0]              out_addr,
    output logic                    out_wr_rd_op,
    output logic [W_WIDTH-1:0]      out_data,
    output logic [7:0]              out_op_id
);

    state_t                   state, state_d;
    logic [SW_ID_WIDTH-1:0]   rr_ptr, rr_ptr_d;
    logic [SW_ID_WIDTH-1:0]   grant, grant_d;
    logic                     valid_d;
    logic                     capture;
    logic                     rd_fifo_d [NUM_SW_INST];
    logic [NUM_SW_INST-1:0]   req;
    logic [SW_ID_WIDTH-1:0]   arb_idx;
    logic                     arb_vld;
    logic [OP_WIDTH-1:0]      sel_word;
    logic                     unused_hi;

    always_comb begin
        for (int i = 0; i < NUM_SW_INST; i++) req[i] = !fifo_empty[i];
    end

    rr_arbiter #(.N(NUM_SW_INST)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign sel_word  = fifo_rd_data[grant];
    assign unused_hi = ^sel_word[OP_WIDTH-1:ADDR_MSB+1];

    // Output handshake: a word transfers on a clock edge where out_valid and
    // out_ready are both high; once out_valid rises, the word and all of its
    // fields hold until that edge. out_ready is ignored while out_valid is low.
    always_comb begin
        state_d  = state;
        grant_d  = grant;
        rr_ptr_d = rr_ptr;
        valid_d  = out_valid;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_idx;
                    state_d = READ;
                end
            end
            READ: begin
                rr_ptr_d = next_ptr(grant, NUM_SW_INST);
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (arb_vld) begin
                        grant_d = arb_idx;
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The pop strobe is registered so it is high for exactly the READ cycle.
        for (int i = 0; i < NUM_SW_INST; i++)
            rd_fifo_d[i] = (state_d == READ) && (grant_d == SW_ID_WIDTH'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            out_valid    <= 1'b0;
            out_sw_id    <= '0;
            out_addr     <= '0;
            out_wr_rd_op <= 1'b0;
            out_data     <= '0;
            out_op_id    <= '0;
            for (int i = 0; i < NUM_SW_INST; i++) rd_fifo[i] <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            grant     <= grant_d;
            out_valid <= valid_d;
            for (int i = 0; i < NUM_SW_INST; i++) rd_fifo[i] <= rd_fifo_d[i];
            if (capture) begin
                out_sw_id    <= grant;
                out_addr     <= sel_word[ADDR_MSB:ADDR_LSB];
                out_wr_rd_op <= sel_word[WR_RD_BIT];
                out_data     <= W_WIDTH'(sel_word[DATA_MSB:DATA_LSB]);
                out_op_id    <= sel_word[OPID_MSB:OPID_LSB];
            end
        end
    end

endmodule

// File: tb/tb_out_mux_arb.sv
// Directed bench for out_mux_arb: FIFO models, expected-word scoreboard,
// protocol monitor and hand-timed latency/backpressure/reset checks.
module tb_out_mux_arb;
    import out_mux_arb_pkg::*;

    localparam int N   = 5;
    localparam int W   = 8;
    localparam int OPW = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   fifo_empty   [N];
    logic [OPW-1:0]         fifo_rd_data [N] = '{default: '0};
    logic                   rd_fifo      [N];
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [SW_ID_WIDTH-1:0] out_sw_id;
    logic [4:0]             out_addr;
    logic                   out_wr_rd_op;
    logic [W-1:0]           out_data;
    logic [7:0]             out_op_id;

    logic [N-1:0]   rd_vec;
    logic [OPW-1:0] mem [N][8];
    int             head [N] = '{default: 0};
    int             tail [N] = '{default: 0};
    logic [24:0]    exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             cnt;

    always #5 clk = ~clk;

    out_mux_arb #(.NUM_SW_INST(N), .W_WIDTH(W), .OP_WIDTH(OPW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .rd_fifo      (rd_fifo),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_sw_id    (out_sw_id),
        .out_addr     (out_addr),
        .out_wr_rd_op (out_wr_rd_op),
        .out_data     (out_data),
        .out_op_id    (out_op_id)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rd_vec[i]     = rd_fifo[i];
            fifo_empty[i] = (head[i] == tail[i]);
        end
    end

    // Result FIFO models: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_fifo[i]) begin
                fifo_rd_data[i] <= mem[i][3'(head[i])];
                head[i]         <= head[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sw, input logic [4:0] a, input logic wr,
                        input logic [7:0] d, input logic [7:0] id, input bit expect_out);
        mem[sw][3'(tail[sw])] = {10'h2A5, a, wr, d, id};
        tail[sw] = tail[sw] + 1;
        if (expect_out) exp_q.push_back({3'(sw), a, wr, d, id});
    endtask

    task automatic drain(input string tag, input int exp_cycles);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            tick();
            cnt++;
        end
        check(tag, 32'(cnt), 32'(exp_cycles));
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, rd_vec, out_valid, out_sw_id, out_addr, out_wr_rd_op, out_data, out_op_id};
    endfunction

    function automatic logic [31:0] present_word();
        return 32'({out_valid, out_sw_id, out_addr, out_wr_rd_op, out_data, out_op_id});
    endfunction

    // Scoreboard on accepted words plus pop-strobe protocol checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                logic [24:0] got, exp;
                got = {out_sw_id, out_addr, out_wr_rd_op, out_data, out_op_id};
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 25'h1FFFFFF;
                check("accept_word", 32'(got), 32'(exp));
            end
            if (|rd_vec) begin
                check("rd_onehot", 32'($countones(rd_vec)), 32'd1);
                for (int i = 0; i < N; i++)
                    if (rd_vec[i]) check("rd_nonempty", 32'(fifo_empty[i]), 32'd0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            out_ready = i[0];
            tick();
            check("idle_quiet", outs(), 32'd0);
        end

        out_ready = 1'b1;
        push(0, 5'h01, 1'b1, 8'h10, 8'hA0, 1'b1);
        push(1, 5'h02, 1'b0, 8'h11, 8'hA1, 1'b1);
        push(4, 5'h03, 1'b1, 8'h12, 8'hA2, 1'b1);
        push(0, 5'h04, 1'b0, 8'h13, 8'hA3, 1'b1);
        push(1, 5'h05, 1'b1, 8'h14, 8'hA4, 1'b1);
        push(4, 5'h06, 1'b0, 8'h15, 8'hA5, 1'b1);
        drain("rr_drain_cycles", 19);
        check("rr_idle_after", 32'(out_valid), 32'd0);

        push(0, 5'h1E, 1'b1, 8'hF0, 8'h5E, 1'b1);
        push(3, 5'h0C, 1'b0, 8'h0F, 8'h3C, 1'b1);
        drain("wrap_drain_cycles", 7);

        push(2, 5'h15, 1'b0, 8'h5A, 8'hC3, 1'b1);
        tick();
        check("single_rd", 32'(rd_vec), 32'h04);
        tick();
        check("single_capture", 32'({rd_vec, out_valid}), 32'd0);
        tick();
        check("single_present", present_word(), 32'({1'b1, 3'd2, 5'h15, 1'b0, 8'h5A, 8'hC3}));
        tick();
        check("single_drop_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        push(3, 5'h0A, 1'b1, 8'h33, 8'h01, 1'b1);
        push(1, 5'h1F, 1'b0, 8'hE7, 8'h02, 1'b1);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bp_latency", 32'(cnt), 32'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", present_word(), 32'({1'b1, 3'd3, 5'h0A, 1'b1, 8'h33, 8'h01}));
            check("bp_no_rd", 32'(rd_vec), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_grant", 32'(rd_vec), 32'h02);
        drain("bp_drain_cycles", 3);
        tick();
        tick();

        out_ready = 1'b0;
        push(1, 5'h05, 1'b1, 8'hAA, 8'h77, 1'b0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(0, 5'h11, 1'b0, 8'h44, 8'h90, 1'b1);
        push(3, 5'h12, 1'b1, 8'h55, 8'h91, 1'b1);
        drain("rst_restart_cycles", 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_mux_arb.md
Name: out_mux_arb

Overview:
- Return-path counterpart of the switch-input demux: collects 22-bit operation words from the per-switch-instance result FIFOs and serialises them onto one output channel.
- Fair round-robin arbitration across NUM_SW_INST instances; FIFO read handshake; output held until the downstream consumer accepts it.
- Sits between the switch instances' result FIFOs and the unit's response port.

Parameters:
- NUM_SW_INST, 5, number of switch instances / result FIFOs (1..8).
- W_WIDTH, 8, data field width.
- OP_WIDTH, 32, FIFO word width; only bits [21:0] are meaningful, upper bits ignored.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1 x [NUM_SW_INST] (unpacked)  per-instance result FIFO empty flag.
- fifo_rd_data  input  OP_WIDTH x [NUM_SW_INST] (unpacked)  per-instance FIFO read data, valid the cycle after its rd_fifo pulse.
- rd_fifo  output  1 x [NUM_SW_INST] (unpacked)  per-instance FIFO pop strobe.
- out_ready  input  1  downstream accepts the current output.
- out_valid  output  1  output word valid.
- out_sw_id  output  3  index of the instance that produced the word.
- out_addr  output  5  word[21:17].
- out_wr_rd_op  output  1  word[16].
- out_data  output  W_WIDTH  word[15:8] (read data for reads, write data echo for writes).
- out_op_id  output  8  word[7:0].

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n. All state and outputs are registered.
- Reset values: state=IDLE, rr_ptr=0, grant=0, all rd_fifo=0, out_valid=0, out_sw_id=0, out_addr=0, out_wr_rd_op=0, out_data=0, out_op_id=0.
- States: IDLE, READ, CAPTURE, PRESENT.
- Arbitration (combinational, on fifo_empty):
  - Search from rr_ptr upward with wrap-around; the first index with fifo_empty=0 wins.
  - The winner is registered as grant.
- IDLE: if any fifo_empty=0, latch grant and go to READ; else stay.
- READ: rd_fifo[grant]=1 for exactly this cycle, all others 0. rr_ptr <= (grant+1) mod NUM_SW_INST. Go to CAPTURE.
- CAPTURE: at the clock edge, latch fields from fifo_rd_data[grant] and out_sw_id<=grant; out_valid<=1. Go to PRESENT.
- PRESENT:
  - Outputs are stable while out_valid=1 and out_ready=0.
  - On out_ready=1, the word is accepted at that edge.
  - If any FIFO is non-empty, arbitrate in the same cycle, latch grant, go to READ with out_valid<=0.
  - Otherwise out_valid<=0 and go to IDLE.
- Latency: FIFO non-empty sampled in IDLE at cycle T -> rd_fifo at T+1 -> out_valid at T+3.
- Sustained throughput: one word per 3 cycles with out_ready tied high.
- At most one rd_fifo bit is high in any cycle, and only in READ. rd_fifo is never asserted to an instance whose fifo_empty was 1 when arbitrated.
- fifo_empty changes while in READ, CAPTURE or PRESENT do not affect the in-flight grant.
- Fairness: a continuously non-empty instance waits at most NUM_SW_INST-1 grants.
- NUM_SW_INST=1: the pointer stays 0; behaviour is otherwise identical.
- Reset asserted mid-operation: everything returns to its reset value immediately. A word already popped but not yet accepted is dropped; this is documented and permitted.
- out_ready while out_valid=0: ignored.

Decomposition:
- Shared package holds:
  - Field positions: ADDR_MSB=21, ADDR_LSB=17, WR_RD_BIT=16, DATA_MSB=15, DATA_LSB=8, OPID_MSB=7, OPID_LSB=0. These are the same constants the input demux packs with.
  - State enum.
  - SW_ID_WIDTH=3.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: gnt_idx, gnt_vld.
  - Purely combinational, instantiated once.

Test Plan:
- Reset then idle: all fifo_empty=1 for 20 cycles -> rd_fifo all 0, out_valid=0, all outputs 0.
- Single word: fifo_empty[2]=0 with fifo_rd_data[2]=22'h2A_5A_C3, i.e. addr=5'h15, wr_rd=0, data=8'h5A, op_id=8'hC3; out_ready=1. Required response:
  - rd_fifo[2] pulses for one cycle.
  - out_valid rises 2 cycles later with out_sw_id=2, out_addr=5'h15, out_wr_rd_op=0, out_data=8'h5A, out_op_id=8'hC3, for 1 cycle.
- Round robin: FIFOs 0, 1, 4 each hold 2 words (stay non-empty) -> grant order 0, 1, 4, 0, 1, 4; no instance is granted twice consecutively while others wait.
- Backpressure: out_ready=0 for 10 cycles with a word presented -> out_valid and all fields stable for those 10 cycles, no rd_fifo pulses; out_ready=1 -> accepted, the next grant follows.
- Pointer wrap: NUM_SW_INST=5, last grant 4, FIFOs 0 and 3 non-empty -> next grant 0, then 3.
- Reset mid-PRESENT: rst_n low asynchronously -> out_valid=0 and rd_fifo=0 before the next clock edge; after release, arbitration restarts from rr_ptr=0.
